// File: rtl/machine_pkg.sv
// Shared encodings for the 8-bit machine: instruction fields, register
// indices, ALU sub-ops, jump conditions and the control FSM states.
package machine_pkg;

  localparam int WIDTH = 8;

  // Register file indices
  localparam logic [2:0] REG_A = 3'd0;
  localparam logic [2:0] REG_B = 3'd1;
  localparam logic [2:0] REG_C = 3'd2;
  localparam logic [2:0] REG_D = 3'd3;
  localparam logic [2:0] REG_E = 3'd4;
  localparam logic [2:0] REG_F = 3'd5;
  localparam logic [2:0] REG_G = 3'd6;
  localparam logic [2:0] REG_T = 3'd7;

  // Whole-byte opcodes
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_HLT = 8'hFF;

  // Instruction group in ir[7:6]
  localparam logic [1:0] GRP_MISC = 2'b00;
  localparam logic [1:0] GRP_MOV  = 2'b01;
  localparam logic [1:0] GRP_ALU  = 2'b10;

  // Misc-group selector in ir[2:0]
  localparam logic [2:0] MISC_LDI = 3'd1;
  localparam logic [2:0] MISC_LD  = 3'd2;
  localparam logic [2:0] MISC_ST  = 3'd3;
  localparam logic [2:0] MISC_JMP = 3'd4;

  // ALU operation in ir[5:3]
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_CMP = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  // Jump condition in ir[5:3]
  localparam logic [2:0] CC_ALWAYS = 3'd0;
  localparam logic [2:0] CC_Z      = 3'd1;
  localparam logic [2:0] CC_NZ     = 3'd2;
  localparam logic [2:0] CC_C      = 3'd3;
  localparam logic [2:0] CC_NC     = 3'd4;

  typedef enum logic [1:0] {
    S_FETCH,
    S_OPERAND,
    S_EXEC,
    S_HALT
  } state_t;

  // True for opcodes that carry an operand byte (LDI, LD, ST, valid jumps).
  // Jumps with an undefined condition code are plain one-byte NOPs.
  function automatic logic is_two_byte(input logic [7:0] op);
    return (op[7:6] == GRP_MISC) &&
           ((op[2:0] == MISC_LDI) || (op[2:0] == MISC_LD) ||
            (op[2:0] == MISC_ST)  ||
            ((op[2:0] == MISC_JMP) && (op[5:3] <= CC_NC)));
  endfunction

endpackage

// File: rtl/cpu.sv
// Multi-cycle CPU: FETCH / OPERAND / EXEC / HALT control, ALU, PC, IR and
// the Z/C flags. Operand bytes land in T and are read back through port B.
module cpu
  import machine_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata
);

  state_t     state = S_FETCH;
  state_t     state_next;
  logic [7:0] pc = '0;
  logic [7:0] ir = '0;
  logic       z  = 1'b0;
  logic       c  = 1'b0;
  logic       halted;

  logic       rf_we;
  logic [2:0] rf_waddr, rf_raddr_a, rf_raddr_b;
  logic [7:0] rf_wdata, rf_rdata_a, rf_rdata_b;

  logic [8:0] alu_wide;
  logic       jump_taken;

  // Decode of the latched instruction
  wire [1:0] grp    = ir[7:6];
  wire [2:0] dst    = ir[5:3];
  wire [2:0] src    = ir[2:0];
  wire       is_hlt = (ir == OP_HLT);
  wire       is_mov = (grp == GRP_MOV);
  wire       is_alu = (grp == GRP_ALU);
  wire       is_ldi = (grp == GRP_MISC) && (src == MISC_LDI);
  wire       is_ld  = (grp == GRP_MISC) && (src == MISC_LD);
  wire       is_st  = (grp == GRP_MISC) && (src == MISC_ST);
  wire       is_jmp = (grp == GRP_MISC) && (src == MISC_JMP) && (dst <= CC_NC);

  // Port A: accumulator for ALU ops, store source for ST, else MOV source.
  // Port B: ALU operand for ALU ops, otherwise the operand latch T.
  assign rf_raddr_a = is_alu ? REG_A : (is_st ? dst : src);
  assign rf_raddr_b = is_alu ? src : REG_T;

  registers m_registers (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rf_raddr_a),
    .raddr_b (rf_raddr_b),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b)
  );

  // ALU: bit 8 carries carry, borrow or the shifted-out bit
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    alu_wide = '0;
    case (dst)
      ALU_ADD: alu_wide = {1'b0, rf_rdata_a} + {1'b0, rf_rdata_b};
      ALU_SUB,
      ALU_CMP: alu_wide = {1'b0, rf_rdata_a} - {1'b0, rf_rdata_b};
      ALU_AND: alu_wide = {1'b0, rf_rdata_a & rf_rdata_b};
      ALU_OR:  alu_wide = {1'b0, rf_rdata_a | rf_rdata_b};
      ALU_XOR: alu_wide = {1'b0, rf_rdata_a ^ rf_rdata_b};
      ALU_SHL: alu_wide = {rf_rdata_a, 1'b0};
      ALU_SHR: alu_wide = {rf_rdata_a[0], 1'b0, rf_rdata_a[7:1]};
      default: alu_wide = '0;
    endcase
  end

  // Jump condition evaluation against the current flags
  always_comb begin
    jump_taken = 1'b0;
    case (dst)
      CC_ALWAYS: jump_taken = 1'b1;
      CC_Z:      jump_taken = z;
      CC_NZ:     jump_taken = ~z;
      CC_C:      jump_taken = c;
      CC_NC:     jump_taken = ~c;
      default:   jump_taken = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // FSM next-state logic; FETCH looks at the byte being fetched
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:   state_next = is_two_byte(mem_rdata) ? S_OPERAND : S_EXEC;
      S_OPERAND: state_next = S_EXEC;
      S_EXEC:    state_next = is_hlt ? S_HALT : S_FETCH;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_FETCH;
    endcase
  end

  // FSM outputs: memory port and register-file write port
  always_comb begin
    halted    = (state == S_HALT);
    mem_addr  = pc;
    mem_wdata = rf_rdata_a;
    mem_we    = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = REG_T;
    rf_wdata  = mem_rdata;
    case (state)
      S_OPERAND: rf_we = 1'b1;
      S_EXEC: begin
        if (is_ld || is_st) mem_addr = rf_rdata_b;
        // Reset wins over a store sitting in EXEC
        mem_we = is_st && !reset;
        if (is_mov) begin
          rf_we    = 1'b1;
          rf_waddr = dst;
          rf_wdata = rf_rdata_a;
        end else if (is_alu) begin
          rf_we    = (dst != ALU_CMP);
          rf_waddr = REG_A;
          rf_wdata = alu_wide[7:0];
        end else if (is_ldi) begin
          rf_we    = 1'b1;
          rf_waddr = dst;
          rf_wdata = rf_rdata_b;
        end else if (is_ld) begin
          rf_we    = 1'b1;
          rf_waddr = dst;
        end
      end
      default: ;
    endcase
  end

  // PC, IR and flag updates; PC wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      ir <= '0;
      z  <= 1'b0;
      c  <= 1'b0;
    end else if (!halted) begin
      case (state)
        S_FETCH: begin
          ir <= mem_rdata;
          pc <= pc + 8'd1;
        end
        S_OPERAND: pc <= pc + 8'd1;
        S_EXEC: begin
          if (is_jmp && jump_taken) pc <= rf_rdata_b;
          if (is_alu) begin
            z <= (alu_wide[7:0] == 8'h00);
            c <= alu_wide[8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram.sv
// 256x8 RAM: combinational read, synchronous write. Contents are loaded
// from outside and survive reset.
module ram (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:255];

  // Write port
  // NOTE: the array is deliberately left out of reset so it maps onto RAM
  // primitives and keeps its preloaded program; sequential state uses <=
  // so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/registers.sv
// Register file: A-G plus the operand latch T, one write port and two
// combinational read ports.
module registers
  import machine_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr_a,
  input  logic [2:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
);

  logic [7:0] rega = '0;
  logic [7:0] regb = '0;
  logic [7:0] regc = '0;
  logic [7:0] regd = '0;
  logic [7:0] rege = '0;
  logic [7:0] regf = '0;
  logic [7:0] regg = '0;
  logic [7:0] regt = '0;

  logic [7:0][7:0] view;

  // Synchronous reset, then a single write per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rega <= '0; regb <= '0; regc <= '0; regd <= '0;
      rege <= '0; regf <= '0; regg <= '0; regt <= '0;
    end else if (we) begin
      case (waddr)
        REG_A: rega <= wdata;
        REG_B: regb <= wdata;
        REG_C: regc <= wdata;
        REG_D: regd <= wdata;
        REG_E: rege <= wdata;
        REG_F: regf <= wdata;
        REG_G: regg <= wdata;
        REG_T: regt <= wdata;
        default: ;
      endcase
    end
  end

  assign view    = {regt, regg, regf, rege, regd, regc, regb, rega};
  assign rdata_a = view[raddr_a];
  assign rdata_b = view[raddr_b];

endmodule

// File: rtl/machine.sv
// Top level: CPU fused to a 256x8 RAM on one clock and reset.
module machine (
  input logic clk,
  input logic reset
);

  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;

  cpu m_cpu (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  ram m_ram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_machine.sv
// Bench for machine: directed programs are loaded into RAM, the expected
// final machine state is queued, and a monitor compares on each rising
// edge of halted.
module tb_machine;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  machine dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] regs [8];
    logic [7:0] pc;
    logic       z;
    logic       c;
    int         cycles;
    bit         mem_chk;
    logic [7:0] mem_addr;
    logic [7:0] mem_val;
  } exp_t;

  exp_t  sb [$];
  int    checks = 0;
  int    errors = 0;
  int    cyc;
  string rn [8] = '{"A", "B", "C", "D", "E", "F", "G", "T"};

  // Cycles from reset release up to and including the edge entering HALT
  always @(posedge clk) begin
    if (reset)                   cyc <= 0;
    else if (!dut.m_cpu.halted)  cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n,
                              input logic [7:0] a, b, c_r, d, e, f, g, t,
                              input logic [7:0] pc, input logic z, c, input int cycles);
    exp_t x;
    x.name    = n;
    x.regs    = '{a, b, c_r, d, e, f, g, t};
    x.pc      = pc;
    x.z       = z;
    x.c       = c;
    x.cycles  = cycles;
    x.mem_chk = 1'b0;
    x.mem_addr = 8'h00;
    x.mem_val  = 8'h00;
    return x;
  endfunction

  // Monitor: one scoreboard entry per rising edge of halted
  initial begin
    bit         prev;
    exp_t       e;
    logic [7:0] got [8];
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (dut.m_cpu.halted && !prev) begin
        if (sb.size() == 0) begin
          check("unexpected_halt", 32'd1, 32'd0);
        end else begin
          e   = sb.pop_front();
          got = '{dut.m_cpu.m_registers.rega, dut.m_cpu.m_registers.regb,
                  dut.m_cpu.m_registers.regc, dut.m_cpu.m_registers.regd,
                  dut.m_cpu.m_registers.rege, dut.m_cpu.m_registers.regf,
                  dut.m_cpu.m_registers.regg, dut.m_cpu.m_registers.regt};
          for (int i = 0; i < 8; i++)
            check($sformatf("%s_reg%s", e.name, rn[i]), 32'(got[i]), 32'(e.regs[i]));
          check({e.name, "_pc"},     32'(dut.m_cpu.pc), 32'(e.pc));
          check({e.name, "_z"},      32'(dut.m_cpu.z),  32'(e.z));
          check({e.name, "_c"},      32'(dut.m_cpu.c),  32'(e.c));
          check({e.name, "_cycles"}, cyc,               e.cycles);
          if (e.mem_chk)
            check({e.name, "_mem"}, 32'(dut.m_ram.mem[e.mem_addr]), 32'(e.mem_val));
        end
      end
      prev = dut.m_cpu.halted;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) dut.m_ram.mem[i] = 8'h00;
  endtask

  task automatic load(input logic [7:0] base, input logic [7:0] bytes [$]);
    for (int i = 0; i < bytes.size(); i++) dut.m_ram.mem[8'(base + 8'(i))] = bytes[i];
  endtask

  // Reset for two cycles, release, wait (bounded) for halt, then idle two cycles
  task automatic run_prog(input string name);
    int n;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!dut.m_cpu.halted && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halt_reached"}, 32'(dut.m_cpu.halted), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;

    // Lone HLT: FETCH + EXEC, everything still zero
    @(negedge clk);
    clear_mem();
    load(8'h00, '{8'hFF});
    sb.push_back(mk("p1_hlt", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 2));
    run_prog("p1_hlt");

    // LDI A,5; LDI B,3; ADD B; HLT -> 3+3+2+2 cycles
    clear_mem();
    load(8'h00, '{8'h01, 8'h05, 8'h09, 8'h03, 8'h81, 8'hFF});
    sb.push_back(mk("p2_add", 8'h08, 8'h03, 0, 0, 0, 0, 0, 8'h03, 8'h06, 0, 0, 10));
    run_prog("p2_add");

    // FF + 01 wraps to 00 with carry; MOV G,A
    clear_mem();
    load(8'h00, '{8'h01, 8'hFF, 8'h09, 8'h01, 8'h81, 8'h70, 8'hFF});
    sb.push_back(mk("p3_carry", 8'h00, 8'h01, 0, 0, 0, 0, 8'h00, 8'h01, 8'h07, 1, 1, 12));
    run_prog("p3_carry");

    // SUB to zero, JZ taken over an HLT to LDI C,77
    clear_mem();
    load(8'h00, '{8'h01, 8'h03, 8'h09, 8'h03, 8'h89, 8'h0C, 8'h0A, 8'hFF,
                  8'h00, 8'h00, 8'h11, 8'h77, 8'hFF});
    sb.push_back(mk("p4_jz", 8'h00, 8'h03, 8'h77, 0, 0, 0, 0, 8'h77, 8'h0D, 1, 0, 16));
    run_prog("p4_jz");

    // Halted holds; then reset clears it and the same program reruns
    check("p4_halt_hold", 32'(dut.m_cpu.halted), 32'd1);
    check("p4_pc_hold",   32'(dut.m_cpu.pc),     32'h0D);
    reset = 1'b1;
    @(negedge clk);
    check("rst_halted", 32'(dut.m_cpu.halted), 32'd0);
    check("rst_pc",     32'(dut.m_cpu.pc),     32'd0);
    check("rst_rega",   32'(dut.m_cpu.m_registers.rega), 32'd0);
    check("rst_regc",   32'(dut.m_cpu.m_registers.regc), 32'd0);
    sb.push_back(mk("p4_rerun", 8'h00, 8'h03, 8'h77, 0, 0, 0, 0, 8'h77, 8'h0D, 1, 0, 16));
    run_prog("p4_rerun");

    // ST A to [00] overwrites the first program byte
    clear_mem();
    load(8'h00, '{8'h01, 8'h5A, 8'h03, 8'h00, 8'hFF});
    e = mk("p5_st", 8'h5A, 0, 0, 0, 0, 0, 0, 8'h00, 8'h05, 0, 0, 8);
    e.mem_chk  = 1'b1;
    e.mem_addr = 8'h00;
    e.mem_val  = 8'h5A;
    sb.push_back(e);
    run_prog("p5_st");

    // Logic ops, SHL, JC taken, CMP borrow, LD, JNZ taken, SHR, JNC not
    // taken, undefined encoding 07 as NOP. Wrong paths land on HLT early.
    clear_mem();
    load(8'h00, '{8'h01, 8'hF0, 8'h09, 8'h3C, 8'h91, 8'h99, 8'hA1, 8'h01,
                  8'h80, 8'hB0, 8'h1C, 8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                  8'hA9, 8'h12, 8'h20, 8'h14, 8'h18, 8'hFF, 8'hFF, 8'hFF,
                  8'h01, 8'h81, 8'hB8, 8'h24, 8'h1F, 8'h07, 8'hFF, 8'h00,
                  8'h9D});
    sb.push_back(mk("p7_mix", 8'h40, 8'h3C, 8'h9D, 0, 0, 0, 0, 8'h1F, 8'h1F, 0, 1, 40));
    run_prog("p7_mix");

    // PC wrap: JMP FF; at FF the LDI opcode takes its operand from 00
    clear_mem();
    load(8'h00, '{8'h04, 8'hFF});
    load(8'hFF, '{8'h01});
    sb.push_back(mk("p8_wrap", 8'h04, 0, 0, 0, 0, 0, 0, 8'h04, 8'h02, 0, 0, 8));
    run_prog("p8_wrap");

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
